exec_stage_seq: RTL and testbench
=================================

Name: exec_stage_seq

Overview:
Parametrised successor to the single-cycle computation stage. It is an iterative execute unit with an operand select, a multi-bit shifter that shifts one bit per cycle, a 4-op ALU, and registered C and status outputs. It sits between the register-file read stage and write-back. Operands are accepted with a valid/ready handshake, and a one-cycle out_valid pulse marks each completed operation.

Parameters:
W, 16, datapath width (>= 4)
IMM_W, 5, immediate field width, zero-extended to W when bsel=1
SHAMT_W, 4, shift-amount field width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand/command valid
in_ready  out  1  unit idle, can accept
a_in  in  W  A operand
b_in  in  W  B operand (goes through shifter)
imm_in  in  IMM_W  immediate
asel  in  1  1: Ain=A, 0: Ain=0
bsel  in  1  1: Bin=zero-extended imm, 0: Bin=shifted B
shift  in  2  00 none, 01 LSL, 10 LSR, 11 ASR
shamt  in  SHAMT_W  shift distance; ignored when shift=00
aluop  in  2  00 add, 01 sub, 10 and, 11 not-B
loadc  in  1  update C on completion
loads  in  1  update status on completion
busy  out  1  high whenever state != IDLE
out_valid  out  1  one-cycle pulse, operation complete
c_out  out  W  registered C
status_out  out  STATUS_W  registered flags; STATUS_W=3 ({V,N,Z}) with macro, 1 ({Z}) without

Behaviour:
- Reset (synchronous, any state): state=IDLE, c_out=0, status_out=0, out_valid=0, counter=0. An in-flight operation is discarded; C and status are not updated.
- in_ready = (state==IDLE) && !reset. Accept occurs at an edge where in_valid && in_ready. All command fields are latched at accept; input changes afterwards are ignored.
- States:
  - IDLE: on accept, go to SHIFT if shift!=00 and eff_shamt>0; otherwise go to EXEC.
  - SHIFT: each cycle shifts the latched B by one bit per the shift code and decrements the counter. When the counter reaches 0, go to EXEC.
  - EXEC: one cycle. Compute ALU, write C if loadc, write status if loads, set out_valid=1 for the next cycle, go to IDLE.
- eff_shamt = min(shamt, W). Shifting by W or more gives 0 for LSL/LSR and all-sign-bits for ASR.
- Latency: out_valid is high in cycle accept+eff_shamt+2 (accept edge = cycle 0). For no shift, out_valid is in cycle 2.
- in_ready returns high in the same cycle out_valid is high, so back-to-back accept is allowed on that edge.
- Shift fill rules: LSL fills the LSB with 0. LSR fills the MSB with 0. ASR replicates the MSB.
- Arithmetic: add and sub are modulo 2^W. Carry is not kept.
- Z = (ALU result == 0), evaluated on the ALU result, not on the old C.
- When loadc=0 or loads=0, the corresponding register holds its value. out_valid still pulses.
- out_valid is never high for two consecutive cycles. No accept is possible while busy.

Optional Feature:
Macro EXEC_STATUS_NV_EN.
- Defined: STATUS_W=3 and status_out={V,N,Z}.
  - N = result[W-1].
  - V for add = (Ain[W-1]==Bin[W-1]) && (result[W-1]!=Ain[W-1]).
  - V for sub = (Ain[W-1]!=Bin[W-1]) && (result[W-1]!=Ain[W-1]).
  - V = 0 for and/not.
- Undefined: STATUS_W=1 and status_out={Z}. No N/V logic is present.

Test Plan:
- W=16, reset 2 cycles -> c_out=0, status_out=0, in_ready=1, busy=0, out_valid=0.
- a=0x0005, b=0x0003, asel=1, bsel=0, shift=00, add, loadc=loads=1 -> out_valid in cycle 2, c_out=0x0008, Z=0.
- b=0x8001, shift=11 (ASR), shamt=3, asel=0, add -> 3 SHIFT cycles, out_valid in cycle 5, c_out=0xF000. Also: shamt=15 with LSR -> c_out=0x0001.
- a=0x7FFF, imm=5'd1, bsel=1, add, with macro -> c_out=0x8000, status={V=1,N=1,Z=0}. Then a=0x0004, b=0x0004, sub, without macro -> c_out=0, status_out=1.
- Assert reset during SHIFT of a shamt=8 LSL -> next cycle state IDLE, c_out=0, no out_valid pulse. Then hold in_valid high at the out_valid cycle -> second op is accepted back-to-back, and loadc=0 leaves c_out unchanged.

Source files
------------

// File: rtl/exec_stage_seq.sv
// exec_stage_seq: iterative execute stage with a 1-bit/cycle shifter, 4-op ALU and registered C/status.
// Optional macro EXEC_STATUS_NV_EN widens status_out from {Z} to {V,N,Z}.
module exec_stage_seq #(
  parameter int W       = 16,
  parameter int IMM_W   = 5,
  parameter int SHAMT_W = 4,
`ifdef EXEC_STATUS_NV_EN
  localparam int STATUS_W = 3
`else
  localparam int STATUS_W = 1
`endif
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        a_in,
  input  logic [W-1:0]        b_in,
  input  logic [IMM_W-1:0]    imm_in,
  input  logic                asel,
  input  logic                bsel,
  input  logic [1:0]          shift,
  input  logic [SHAMT_W-1:0]  shamt,
  input  logic [1:0]          aluop,
  input  logic                loadc,
  input  logic                loads,
  output logic                busy,
  output logic                out_valid,
  output logic [W-1:0]        c_out,
  output logic [STATUS_W-1:0] status_out
);

  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, EXEC = 2'd2} state_t;

  state_t               state_r, state_next_s;
  logic [W-1:0]         a_r, b_r, ain_s, bin_s, res_s;
  logic [IMM_W-1:0]     imm_r;
  logic                 asel_r, bsel_r, loadc_r, loads_r;
  logic [1:0]           shift_r, aluop_r;
  logic [CNT_W-1:0]     cnt_r, eff_shamt_s;
  logic                 accept_s;
  logic [STATUS_W-1:0]  status_next_s;

  function automatic logic [W-1:0] shift_one(input logic [W-1:0] v, input logic [1:0] code);
    logic [W-1:0] r;
    case (code)
      2'b01:   r = {v[W-2:0], 1'b0};
      2'b10:   r = {1'b0, v[W-1:1]};
      2'b11:   r = {v[W-1], v[W-1:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  assign in_ready = (state_r == IDLE) && !reset;
  assign busy     = (state_r != IDLE);
  assign accept_s = in_valid && in_ready;

  // Distances of W or more saturate: W one-bit steps already give the fully shifted value.
  always_comb begin
    if (32'(shamt) >= 32'(W)) begin
      eff_shamt_s = CNT_W'(W);
    end else begin
      eff_shamt_s = CNT_W'(shamt);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if ((shift != 2'b00) && (eff_shamt_s != {CNT_W{1'b0}})) begin
            state_next_s = SHIFT;
          end else begin
            state_next_s = EXEC;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_r <= CNT_W'(1)) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = SHIFT;
        end
      end
      EXEC:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Command latch at accept; B and the counter then step once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      imm_r   <= {IMM_W{1'b0}};
      asel_r  <= 1'b0;
      bsel_r  <= 1'b0;
      shift_r <= 2'b00;
      aluop_r <= 2'b00;
      loadc_r <= 1'b0;
      loads_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      a_r     <= a_in;
      b_r     <= b_in;
      imm_r   <= imm_in;
      asel_r  <= asel;
      bsel_r  <= bsel;
      shift_r <= shift;
      aluop_r <= aluop;
      loadc_r <= loadc;
      loads_r <= loads;
      cnt_r   <= eff_shamt_s;
    end else if (state_r == SHIFT) begin
      b_r     <= shift_one(b_r, shift_r);
      cnt_r   <= cnt_r - CNT_W'(1);
    end
  end

  // Operand select and ALU.
  always_comb begin
    ain_s = asel_r ? a_r : {W{1'b0}};
    bin_s = bsel_r ? W'(imm_r) : b_r;
    res_s = {W{1'b0}};
    case (aluop_r)
      2'b00:   res_s = ain_s + bin_s;
      2'b01:   res_s = ain_s - bin_s;
      2'b10:   res_s = ain_s & bin_s;
      2'b11:   res_s = ~bin_s;
      default: res_s = {W{1'b0}};
    endcase
  end

`ifdef EXEC_STATUS_NV_EN
  logic v_s;

  // Signed overflow of add/sub; logical ops never overflow.
  always_comb begin
    v_s = 1'b0;
    case (aluop_r)
      2'b00:   v_s = (ain_s[W-1] == bin_s[W-1]) && (res_s[W-1] != ain_s[W-1]);
      2'b01:   v_s = (ain_s[W-1] != bin_s[W-1]) && (res_s[W-1] != ain_s[W-1]);
      default: v_s = 1'b0;
    endcase
  end

  assign status_next_s = {v_s, res_s[W-1], (res_s == {W{1'b0}})};
`else
  assign status_next_s = (res_s == {W{1'b0}});
`endif

  // Registered results; out_valid pulses for the cycle after EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      c_out      <= {W{1'b0}};
      status_out <= {STATUS_W{1'b0}};
    end else begin
      out_valid <= (state_r == EXEC);
      if ((state_r == EXEC) && loadc_r) begin
        c_out <= res_s;
      end
      if ((state_r == EXEC) && loads_r) begin
        status_out <= status_next_s;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage_seq.sv
// Self-checking bench for exec_stage_seq: directed plan cases plus randomized traffic against a behavioural model.
module tb_exec_stage_seq;
  localparam int W       = 16;
  localparam int IMM_W   = 5;
  localparam int SHAMT_W = 4;
`ifdef EXEC_STATUS_NV_EN
  localparam int STATUS_W = 3;
`else
  localparam int STATUS_W = 1;
`endif

  logic                clk = 1'b0;
  logic                reset, in_valid, in_ready, asel, bsel, loadc, loads, busy, out_valid;
  logic [W-1:0]        a_in, b_in, c_out;
  logic [IMM_W-1:0]    imm_in;
  logic [1:0]          shift, aluop;
  logic [SHAMT_W-1:0]  shamt;
  logic [STATUS_W-1:0] status_out;

  exec_stage_seq #(.W(W), .IMM_W(IMM_W), .SHAMT_W(SHAMT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .imm_in(imm_in), .asel(asel), .bsel(bsel),
    .shift(shift), .shamt(shamt), .aluop(aluop), .loadc(loadc), .loads(loads),
    .busy(busy), .out_valid(out_valid), .c_out(c_out), .status_out(status_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole shift applied at once, overflow judged from signed integer range.
  function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic [IMM_W-1:0] imm,
                               input logic as, input logic bs, input logic [1:0] sh,
                               input logic [SHAMT_W-1:0] sa, input logic [1:0] op,
                               output logic [W-1:0] r, output logic [STATUS_W-1:0] st, output int e);
    logic [W-1:0] bsh, ain, bin;
    int sr;
    logic v;
    e = (sh == 2'b00) ? 0 : ((int'(sa) > W) ? W : int'(sa));
    case (sh)
      2'b01:   bsh = b << e;
      2'b10:   bsh = b >> e;
      2'b11:   bsh = $signed(b) >>> e;
      default: bsh = b;
    endcase
    ain = as ? a : '0;
    bin = bs ? W'(imm) : bsh;
    v = 1'b0;
    case (op)
      2'b00: begin r = ain + bin; sr = int'($signed(ain)) + int'($signed(bin)); v = (sr > 32767) || (sr < -32768); end
      2'b01: begin r = ain - bin; sr = int'($signed(ain)) - int'($signed(bin)); v = (sr > 32767) || (sr < -32768); end
      2'b10: r = ain & bin;
      default: r = ~bin;
    endcase
`ifdef EXEC_STATUS_NV_EN
    st = {v, r[W-1], (r == '0)};
`else
    st = (r == '0);
`endif
  endfunction

  // Behavioural model: at most one op in flight, completing a fixed number of edges after accept.
  int                  cyc = 0;
  int                  due = 0;
  int                  m_e;
  logic                pend = 1'b0, exp_ov = 1'b0, m_rdy, p_lc, p_ls, chk_en = 1'b0;
  logic [W-1:0]        m_c = '0, p_c;
  logic [STATUS_W-1:0] m_st = '0, p_st;

  always @(posedge clk) begin
    cyc = cyc + 1;
    m_rdy = !pend && !reset;
    exp_ov = 1'b0;
    if (reset) begin
      pend = 1'b0; m_c = '0; m_st = '0;
    end else begin
      if (pend && cyc == due) begin
        exp_ov = 1'b1; pend = 1'b0;
        if (p_lc) m_c = p_c;
        if (p_ls) m_st = p_st;
      end
      if (m_rdy && in_valid) begin
        calc(a_in, b_in, imm_in, asel, bsel, shift, shamt, aluop, p_c, p_st, m_e);
        p_lc = loadc; p_ls = loads; due = cyc + m_e + 1; pend = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, !pend && !reset);
      chk("busy", busy, pend);
      chk("c_out", c_out, m_c);
      chk("status_out", status_out, m_st);
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [IMM_W-1:0] imm,
                       input logic as, input logic bs, input logic [1:0] sh,
                       input logic [SHAMT_W-1:0] sa, input logic [1:0] op, input logic lc, input logic ls);
    a_in = a; b_in = b; imm_in = imm; asel = as; bsel = bs; shift = sh;
    shamt = sa; aluop = op; loadc = lc; loads = ls; in_valid = 1'b1;
  endtask

  task automatic wait_ready_and_accept(input string name);
    int k = 0;
    @(negedge clk);
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    if (!in_ready) chk({name, " ready timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 100);
    chk({name, " latency"}, n, exp_lat);
  endtask

  task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [IMM_W-1:0] imm, input logic as, input logic bs, input logic [1:0] sh,
                    input logic [SHAMT_W-1:0] sa, input logic [1:0] aop, input int exp_lat,
                    input logic [W-1:0] exp_c, input logic [STATUS_W-1:0] exp_st);
    drive(a, b, imm, as, bs, sh, sa, aop, 1'b1, 1'b1);
    wait_ready_and_accept(name);
    in_valid = 1'b0;
    wait_done(name, exp_lat);
    chk({name, " c"}, c_out, exp_c);
    chk({name, " status"}, status_out, exp_st);
  endtask

  int saw;
  logic [STATUS_W-1:0] st_c;

  initial begin
    reset = 1'b1;
    drive('0, '0, '0, 1'b0, 1'b0, 2'b00, '0, 2'b00, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1 chk_en = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("reset c_out", c_out, 32'd0);
    chk("reset status", status_out, 32'd0);
    chk("reset in_ready", in_ready, 32'd1);
    chk("reset busy", busy, 32'd0);
    chk("reset out_valid", out_valid, 32'd0);

    op("add5+3",  16'h0005, 16'h0003, 5'd0, 1'b1, 1'b0, 2'b00, 4'd0,  2'b00, 2,  16'h0008, '0);
`ifdef EXEC_STATUS_NV_EN
    st_c = 3'b010;
`else
    st_c = 1'b0;
`endif
    op("asr3",    16'h0000, 16'h8001, 5'd0, 1'b0, 1'b0, 2'b11, 4'd3,  2'b00, 5,  16'hF000, st_c);
    op("lsr15",   16'h0000, 16'h8001, 5'd0, 1'b0, 1'b0, 2'b10, 4'd15, 2'b00, 17, 16'h0001, '0);
    op("lsl0",    16'h0000, 16'h0007, 5'd0, 1'b0, 1'b0, 2'b01, 4'd0,  2'b00, 2,  16'h0007, '0);
`ifdef EXEC_STATUS_NV_EN
    st_c = 3'b110;
`else
    st_c = 1'b0;
`endif
    op("imm_ovf", 16'h7FFF, 16'h1234, 5'd1, 1'b1, 1'b1, 2'b00, 4'd0,  2'b00, 2,  16'h8000, st_c);
    op("sub_zero",16'h0004, 16'h0004, 5'd0, 1'b1, 1'b0, 2'b00, 4'd0,  2'b01, 2,  16'h0000, 1);
    op("and",     16'hFF00, 16'h0FF0, 5'd0, 1'b1, 1'b0, 2'b00, 4'd0,  2'b10, 2,  16'h0F00, '0);
`ifdef EXEC_STATUS_NV_EN
    st_c = 3'b010;
`else
    st_c = 1'b0;
`endif
    op("notb",    16'h1111, 16'h00F0, 5'd0, 1'b1, 1'b0, 2'b00, 4'd0,  2'b11, 2,  16'hFF0F, st_c);

    // Reset in the middle of an 8-step LSL: the op is dropped.
    drive(16'h0000, 16'h0001, 5'd0, 1'b0, 1'b0, 2'b01, 4'd8, 2'b00, 1'b1, 1'b1);
    wait_ready_and_accept("rst_mid");
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_mid busy", busy, 32'd0);
    chk("rst_mid c_out", c_out, 32'd0);
    saw = 0;
    repeat (12) begin if (out_valid) saw++; @(negedge clk); end
    chk("rst_mid no pulse", saw, 32'd0);

    // Back-to-back: second op accepted on the out_valid edge, with loadc=0.
    drive(16'h0001, 16'h0002, 5'd0, 1'b1, 1'b0, 2'b00, 4'd0, 2'b00, 1'b1, 1'b1);
    wait_ready_and_accept("b2b_a");
    drive(16'h00FF, 16'h0100, 5'd0, 1'b1, 1'b0, 2'b00, 4'd0, 2'b00, 1'b0, 1'b1);
    wait_done("b2b_a", 2);
    chk("b2b_a c", c_out, 32'h0003);
    chk("b2b_a ready", in_ready, 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_b accepted", busy, 32'd1);
    chk("b2b_b no pulse", out_valid, 32'd0);
    saw = 1;
    while (!out_valid && saw < 100) begin @(negedge clk); saw++; end
    chk("b2b_b latency", saw, 32'd2);
    chk("b2b_b c held", c_out, 32'h0003);
    chk("b2b_b status", status_out, 32'd0);

    // Randomized traffic; inputs keep changing while busy, occasional resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset    = ($urandom_range(99) == 0);
      in_valid = ($urandom_range(2) != 0);
      a_in = W'($urandom); b_in = W'($urandom); imm_in = IMM_W'($urandom);
      asel = 1'($urandom); bsel = 1'($urandom); shift = 2'($urandom);
      shamt = SHAMT_W'($urandom); aluop = 2'($urandom);
      loadc = 1'($urandom); loads = 1'($urandom);
      if ($urandom_range(7) == 0) b_in = (i % 2 == 0) ? 16'h0000 : 16'h8000;
    end
    @(posedge clk); #1 reset = 1'b0; in_valid = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
